alu_control_regfile: RTL and testbench

Execute-stage core of the single-issue MIPS pipeline: register file, instruction decode (control unit) and ALU in one block. It receives the instruction currently in EX and the writeback port from WB. It produces operand data, ALU results, the HI/LO registers and the control strobes the surrounding pipeline registers consume.

---
 rtl/alu_control_regfile.sv | 207 ++++++++++++++++++++
 tb/tb_alu_control_regfile.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_control_regfile.sv
// Execute-stage core of the single-issue MIPS pipeline: 32x32 register file with
// write-through bypass, instruction decode, ALU and the architectural HI/LO pair.
module alu_control_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction_EX,
    input  logic        stall_EX,
    input  logic        we,
    input  logic [4:0]  writeaddr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata1,
    output logic [31:0] readdata2,
    output logic [31:0] alu_hi,
    output logic [31:0] alu_lo,
    output logic        zero,
    output logic [31:0] hi_reg,
    output logic [31:0] lo_reg,
    output logic        regwrite_EX,
    output logic        rdrt_EX,
    output logic        memwrite_EX,
    output logic        enhilo_EX,
    output logic        gpio_out_en,
    output logic        gpio_in_en,
    output logic [1:0]  regsel_EX
);

    typedef enum logic [3:0] {
        OP_AND  = 4'd0,  OP_OR   = 4'd1,  OP_XOR = 4'd2,  OP_NOR  = 4'd3,
        OP_ADD  = 4'd4,  OP_SUB  = 4'd5,  OP_MULT = 4'd6, OP_MULTU = 4'd7,
        OP_SLT  = 4'd8,  OP_SLTU = 4'd9,  OP_SLL = 4'd10, OP_SRL  = 4'd11,
        OP_SRA  = 4'd12
    } alu_op_t;

    typedef enum logic [1:0] {
        SRC_REG  = 2'b00,
        SRC_SEXT = 2'b01,
        SRC_ZEXT = 2'b10
    } alu_src_t;

    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  instr_shamt;
    logic [5:0]  funct;
    logic [15:0] imm;

    assign opcode      = instruction_EX[31:26];
    assign rs          = instruction_EX[25:21];
    assign rt          = instruction_EX[20:16];
    assign instr_shamt = instruction_EX[10:6];
    assign funct       = instruction_EX[5:0];
    assign imm         = instruction_EX[15:0];

    // ---------------- register file ----------------
    logic [31:0] regs [32];

    // NOTE: the array is reset on purpose -- rst must clear every register at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && writeaddr != 5'd0) begin
            regs[writeaddr] <= writedata;
        end
    end

    // Bypass is suppressed in reset so reads agree with the (ignored) write.
    always_comb begin
        readdata1 = '0;
        readdata2 = '0;
        if (rs != 5'd0) begin
            readdata1 = (we && !rst && writeaddr == rs) ? writedata : regs[rs];
        end
        if (rt != 5'd0) begin
            readdata2 = (we && !rst && writeaddr == rt) ? writedata : regs[rt];
        end
    end

    // ---------------- decode ----------------
    alu_op_t  alu_op;
    alu_src_t alu_src;
    logic [4:0] shamt;
    logic regwrite, memwrite, enhilo, gpio_in, gpio_out;

    // NOTE: every decode output gets a default first so no path infers a latch.
    always_comb begin
        alu_op    = OP_ADD;
        alu_src   = SRC_REG;
        shamt     = 5'd0;
        regsel_EX = 2'b00;
        regwrite  = 1'b0;
        rdrt_EX   = 1'b0;
        memwrite  = 1'b0;
        enhilo    = 1'b0;
        gpio_in   = 1'b0;
        gpio_out  = 1'b0;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h20, 6'h21: begin alu_op = OP_ADD;  regwrite = 1'b1; end
                    6'h22, 6'h23: begin alu_op = OP_SUB;  regwrite = 1'b1; end
                    6'h24:        begin alu_op = OP_AND;  regwrite = 1'b1; end
                    6'h25:        begin alu_op = OP_OR;   regwrite = 1'b1; end
                    6'h26:        begin alu_op = OP_XOR;  regwrite = 1'b1; end
                    6'h27:        begin alu_op = OP_NOR;  regwrite = 1'b1; end
                    6'h2A:        begin alu_op = OP_SLT;  regwrite = 1'b1; end
                    6'h2B:        begin alu_op = OP_SLTU; regwrite = 1'b1; end
                    6'h00: begin alu_op = OP_SLL; shamt = instr_shamt; regwrite = 1'b1; end
                    6'h02: begin alu_op = OP_SRL; shamt = instr_shamt; regwrite = 1'b1; end
                    6'h03: begin alu_op = OP_SRA; shamt = instr_shamt; regwrite = 1'b1; end
                    6'h18:        begin alu_op = OP_MULT;  enhilo = 1'b1; end
                    6'h19:        begin alu_op = OP_MULTU; enhilo = 1'b1; end
                    6'h10:        begin regsel_EX = 2'b01; regwrite = 1'b1; end
                    6'h12:        begin regsel_EX = 2'b10; regwrite = 1'b1; end
                    default: ;
                endcase
            end
            6'h08, 6'h09: begin alu_op = OP_ADD;  alu_src = SRC_SEXT; regwrite = 1'b1; rdrt_EX = 1'b1; end
            6'h0A:        begin alu_op = OP_SLT;  alu_src = SRC_SEXT; regwrite = 1'b1; rdrt_EX = 1'b1; end
            6'h0B:        begin alu_op = OP_SLTU; alu_src = SRC_SEXT; regwrite = 1'b1; rdrt_EX = 1'b1; end
            6'h0C:        begin alu_op = OP_AND;  alu_src = SRC_ZEXT; regwrite = 1'b1; rdrt_EX = 1'b1; end
            6'h0D:        begin alu_op = OP_OR;   alu_src = SRC_ZEXT; regwrite = 1'b1; rdrt_EX = 1'b1; end
            6'h0E:        begin alu_op = OP_XOR;  alu_src = SRC_ZEXT; regwrite = 1'b1; rdrt_EX = 1'b1; end
            6'h0F: begin
                alu_op   = OP_SLL;
                alu_src  = SRC_ZEXT;
                shamt    = 5'd16;
                regwrite = 1'b1;
                rdrt_EX  = 1'b1;
            end
            6'h2B: begin alu_op = OP_ADD; alu_src = SRC_SEXT; memwrite = 1'b1; end
            6'h10: begin
                if (funct == 6'h00) begin
                    gpio_in  = 1'b1;
                    regwrite = 1'b1;
                    rdrt_EX  = 1'b1;
                end else if (funct == 6'h04) begin
                    gpio_out = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // A stalled instruction still computes but must not commit anything.
    assign regwrite_EX = regwrite & ~stall_EX;
    assign memwrite_EX = memwrite & ~stall_EX;
    assign enhilo_EX   = enhilo   & ~stall_EX;
    assign gpio_in_en  = gpio_in  & ~stall_EX;
    assign gpio_out_en = gpio_out & ~stall_EX;

    // ---------------- ALU ----------------
    logic [31:0]        op_a;
    logic [31:0]        op_b;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;

    assign op_a = readdata1;

    always_comb begin
        case (alu_src)
            SRC_SEXT: op_b = {{16{imm[15]}}, imm};
            SRC_ZEXT: op_b = {16'd0, imm};
            default:  op_b = readdata2;
        endcase
    end

    assign prod_s = $signed(op_a) * $signed(op_b);
    assign prod_u = {32'd0, op_a} * {32'd0, op_b};

    always_comb begin
        alu_hi = '0;
        alu_lo = '0;
        case (alu_op)
            OP_AND:   alu_lo = op_a & op_b;
            OP_OR:    alu_lo = op_a | op_b;
            OP_XOR:   alu_lo = op_a ^ op_b;
            OP_NOR:   alu_lo = ~(op_a | op_b);
            OP_ADD:   alu_lo = op_a + op_b;
            OP_SUB:   alu_lo = op_a - op_b;
            OP_MULT:  {alu_hi, alu_lo} = prod_s;
            OP_MULTU: {alu_hi, alu_lo} = prod_u;
            OP_SLT:   alu_lo = {31'd0, $signed(op_a) < $signed(op_b)};
            OP_SLTU:  alu_lo = {31'd0, op_a < op_b};
            OP_SLL:   alu_lo = op_b << shamt;
            OP_SRL:   alu_lo = op_b >> shamt;
            OP_SRA:   alu_lo = $unsigned($signed(op_b) >>> shamt);
            default:  alu_lo = '0;
        endcase
    end

    assign zero = (alu_lo == 32'd0);

    // ---------------- HI/LO ----------------
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else if (enhilo_EX) begin
            hi_reg <= alu_hi;
            lo_reg <= alu_lo;
        end
    end

endmodule

// File: tb/tb_alu_control_regfile.sv
// Self-checking bench for alu_control_regfile: decode/ALU vector table through a
// scoreboard queue, plus hand-written bypass, HI/LO and reset sequences.
module tb_alu_control_regfile;

    logic        clk;
    logic        rst;
    logic [31:0] instruction_EX;
    logic        stall_EX;
    logic        we;
    logic [4:0]  writeaddr;
    logic [31:0] writedata;
    logic [31:0] readdata1, readdata2, alu_hi, alu_lo, hi_reg, lo_reg;
    logic        zero, regwrite_EX, rdrt_EX, memwrite_EX, enhilo_EX, gpio_out_en, gpio_in_en;
    logic [1:0]  regsel_EX;

    alu_control_regfile dut (
        .clk(clk), .rst(rst), .instruction_EX(instruction_EX), .stall_EX(stall_EX),
        .we(we), .writeaddr(writeaddr), .writedata(writedata),
        .readdata1(readdata1), .readdata2(readdata2), .alu_hi(alu_hi), .alu_lo(alu_lo),
        .zero(zero), .hi_reg(hi_reg), .lo_reg(lo_reg),
        .regwrite_EX(regwrite_EX), .rdrt_EX(rdrt_EX), .memwrite_EX(memwrite_EX),
        .enhilo_EX(enhilo_EX), .gpio_out_en(gpio_out_en), .gpio_in_en(gpio_in_en),
        .regsel_EX(regsel_EX)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        stall;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        zero;
        logic [5:0]  ctl;     // {regwrite, rdrt, memwrite, enhilo, gpio_out, gpio_in}
        logic [1:0]  regsel;
    } vec_t;

    vec_t vecs[22];
    vec_t sb[$];
    vec_t exp_v;
    int   tests;
    int   fails;

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1;
        writeaddr = a;
        writedata = d;
        @(posedge clk);
        #1 we = 1'b0;
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        we = 1'b0;
        writeaddr = '0;
        writedata = '0;
        stall_EX = 1'b0;
        instruction_EX = rtype(5'd5, 5'd0, 5'd0, 5'd0, 6'h20);
        tests = 0;
        fails = 0;

        // Preloaded values: r1=0, r2=2, r3=-1, r4=0x80000000, r5=0x1234, r6=1
        vecs[0]  = '{"addi",     itype(6'h08, 5'd1, 5'd2, 16'hFFFF), 1'b0, 32'h0,        32'h2,        32'hFFFFFFFF, 32'h0,        1'b0, 6'b110000, 2'b00};
        vecs[1]  = '{"andi",     itype(6'h0C, 5'd3, 5'd7, 16'hFFFF), 1'b0, 32'hFFFFFFFF, 32'h0,        32'h0000FFFF, 32'h0,        1'b0, 6'b110000, 2'b00};
        vecs[2]  = '{"mult",     rtype(5'd3, 5'd2, 5'd0, 5'd0, 6'h18), 1'b0, 32'hFFFFFFFF, 32'h2,      32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0, 6'b000100, 2'b00};
        vecs[3]  = '{"multu",    rtype(5'd3, 5'd2, 5'd0, 5'd0, 6'h19), 1'b0, 32'hFFFFFFFF, 32'h2,      32'hFFFFFFFE, 32'h1,        1'b0, 6'b000100, 2'b00};
        vecs[4]  = '{"sra",      rtype(5'd0, 5'd4, 5'd8, 5'd4, 6'h03), 1'b0, 32'h0,        32'h80000000, 32'hF8000000, 32'h0,      1'b0, 6'b100000, 2'b00};
        vecs[5]  = '{"lui",      itype(6'h0F, 5'd0, 5'd9, 16'hABCD), 1'b0, 32'h0,        32'h0,        32'hABCD0000, 32'h0,        1'b0, 6'b110000, 2'b00};
        vecs[6]  = '{"slt",      rtype(5'd3, 5'd6, 5'd10, 5'd0, 6'h2A), 1'b0, 32'hFFFFFFFF, 32'h1,     32'h1,        32'h0,        1'b0, 6'b100000, 2'b00};
        vecs[7]  = '{"sltu",     rtype(5'd3, 5'd6, 5'd10, 5'd0, 6'h2B), 1'b0, 32'hFFFFFFFF, 32'h1,     32'h0,        32'h0,        1'b1, 6'b100000, 2'b00};
        vecs[8]  = '{"gpio_out_stall", {6'h10, 20'd0, 6'h04}, 1'b1, 32'h0,           32'h0,        32'h0,        32'h0,        1'b1, 6'b000000, 2'b00};
        vecs[9]  = '{"gpio_out", {6'h10, 20'd0, 6'h04},      1'b0, 32'h0,            32'h0,        32'h0,        32'h0,        1'b1, 6'b000010, 2'b00};
        vecs[10] = '{"gpio_in",  {6'h10, 20'd0, 6'h00},      1'b0, 32'h0,            32'h0,        32'h0,        32'h0,        1'b1, 6'b110001, 2'b00};
        vecs[11] = '{"undef_3f", itype(6'h3F, 5'd3, 5'd6, 16'h1234), 1'b0, 32'hFFFFFFFF, 32'h1,        32'h0,        32'h0,        1'b1, 6'b000000, 2'b00};
        vecs[12] = '{"mfhi",     rtype(5'd0, 5'd0, 5'd11, 5'd0, 6'h10), 1'b0, 32'h0,       32'h0,        32'h0,        32'h0,        1'b1, 6'b100000, 2'b01};
        vecs[13] = '{"sw",       itype(6'h2B, 5'd2, 5'd3, 16'h0010), 1'b0, 32'h2,        32'hFFFFFFFF, 32'h12,       32'h0,        1'b0, 6'b001000, 2'b00};
        vecs[14] = '{"sub",      rtype(5'd6, 5'd2, 5'd12, 5'd0, 6'h22), 1'b0, 32'h1,       32'h2,        32'hFFFFFFFF, 32'h0,        1'b0, 6'b100000, 2'b00};
        vecs[15] = '{"nor",      rtype(5'd1, 5'd6, 5'd12, 5'd0, 6'h27), 1'b0, 32'h0,       32'h1,        32'hFFFFFFFE, 32'h0,        1'b0, 6'b100000, 2'b00};
        vecs[16] = '{"ori",      itype(6'h0D, 5'd4, 5'd5, 16'h8001), 1'b0, 32'h80000000, 32'h1234,     32'h80008001, 32'h0,        1'b0, 6'b110000, 2'b00};
        vecs[17] = '{"xori",     itype(6'h0E, 5'd3, 5'd0, 16'h00FF), 1'b0, 32'hFFFFFFFF, 32'h0,        32'hFFFFFF00, 32'h0,        1'b0, 6'b110000, 2'b00};
        vecs[18] = '{"sll31",    rtype(5'd0, 5'd6, 5'd12, 5'd31, 6'h00), 1'b0, 32'h0,      32'h1,        32'h80000000, 32'h0,        1'b0, 6'b100000, 2'b00};
        vecs[19] = '{"srl31",    rtype(5'd0, 5'd4, 5'd12, 5'd31, 6'h02), 1'b0, 32'h0,      32'h80000000, 32'h1,        32'h0,        1'b0, 6'b100000, 2'b00};
        vecs[20] = '{"slti",     itype(6'h0A, 5'd3, 5'd0, 16'h0000), 1'b0, 32'hFFFFFFFF, 32'h0,        32'h1,        32'h0,        1'b0, 6'b110000, 2'b00};
        vecs[21] = '{"sltiu",    itype(6'h0B, 5'd6, 5'd0, 16'hFFFF), 1'b0, 32'h1,        32'h0,        32'h1,        32'h0,        1'b0, 6'b110000, 2'b00};

        // Power-on reset
        #12;
        check("reset_rd1_r5", readdata1, 32'h0);
        check("reset_hi_reg", hi_reg, 32'h0);
        check("reset_lo_reg", lo_reg, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        write_reg(5'd2, 32'h2);
        write_reg(5'd3, 32'hFFFFFFFF);
        write_reg(5'd4, 32'h80000000);
        write_reg(5'd6, 32'h1);

        // Write-through bypass, then the registered value
        @(negedge clk);
        instruction_EX = rtype(5'd5, 5'd0, 5'd0, 5'd0, 6'h20);
        we = 1'b1;
        writeaddr = 5'd5;
        writedata = 32'h1234;
        #1 check("bypass_rd1", readdata1, 32'h1234);
        @(posedge clk);
        #1 we = 1'b0;
        #1 check("reg_rd1_r5", readdata1, 32'h1234);

        // Writes to r0 are discarded, bypass included
        @(negedge clk);
        instruction_EX = rtype(5'd0, 5'd0, 5'd0, 5'd0, 6'h20);
        we = 1'b1;
        writeaddr = 5'd0;
        writedata = 32'hDEAD;
        #1 check("r0_bypass", readdata1, 32'h0);
        @(posedge clk);
        #1 we = 1'b0;
        #1 check("r0_after_write", readdata1, 32'h0);

        // Decode/ALU vector table through the scoreboard
        for (int i = 0; i < 22; i++) begin
            @(posedge clk);
            #1;
            instruction_EX = vecs[i].instr;
            stall_EX = vecs[i].stall;
            sb.push_back(vecs[i]);
            @(negedge clk);
            exp_v = sb.pop_front();
            check({exp_v.name, "_rd1"}, readdata1, exp_v.rd1);
            check({exp_v.name, "_rd2"}, readdata2, exp_v.rd2);
            check({exp_v.name, "_alu_lo"}, alu_lo, exp_v.lo);
            check({exp_v.name, "_alu_hi"}, alu_hi, exp_v.hi);
            check({exp_v.name, "_zero"}, zero, exp_v.zero);
            check({exp_v.name, "_ctl"}, {regwrite_EX, rdrt_EX, memwrite_EX, enhilo_EX, gpio_out_en, gpio_in_en}, exp_v.ctl);
            check({exp_v.name, "_regsel"}, regsel_EX, exp_v.regsel);
        end
        stall_EX = 1'b0;

        // HI/LO: load on mult, hold under stall, load on multu alongside a write
        @(negedge clk);
        instruction_EX = rtype(5'd3, 5'd2, 5'd0, 5'd0, 6'h18);
        @(posedge clk);
        #1 check("mult_hi_reg", hi_reg, 32'hFFFFFFFF);
        check("mult_lo_reg", lo_reg, 32'hFFFFFFFE);
        instruction_EX = rtype(5'd3, 5'd2, 5'd0, 5'd0, 6'h19);
        stall_EX = 1'b1;
        @(posedge clk);
        #1 check("stall_hi_hold", hi_reg, 32'hFFFFFFFF);
        check("stall_lo_hold", lo_reg, 32'hFFFFFFFE);
        stall_EX = 1'b0;
        we = 1'b1;
        writeaddr = 5'd13;
        writedata = 32'h66;
        @(posedge clk);
        #1 we = 1'b0;
        check("multu_hi_reg", hi_reg, 32'h1);
        check("multu_lo_reg", lo_reg, 32'hFFFFFFFE);
        instruction_EX = rtype(5'd13, 5'd0, 5'd0, 5'd0, 6'h20);
        #1 check("write_with_enhilo", readdata1, 32'h66);

        // Asynchronous reset mid-cycle clears everything; writes during reset are ignored
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check("async_rst_hi", hi_reg, 32'h0);
        check("async_rst_lo", lo_reg, 32'h0);
        @(negedge clk);
        we = 1'b1;
        writeaddr = 5'd2;
        writedata = 32'hBEEF;
        @(posedge clk);
        #1 we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            instruction_EX = rtype(5'(i), 5'd0, 5'd0, 5'd0, 6'h20);
            #1 check($sformatf("rst_r%0d", i), readdata1, 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        instruction_EX = rtype(5'd2, 5'd0, 5'd0, 5'd0, 6'h20);
        #1 check("write_during_rst_ignored", readdata1, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
